// File: rtl/riscv32f_pkg.sv
// Shared RV32F definitions: rounding-mode encodings, exponent bias and
// the state encoding of the multi-cycle conversion units.
package riscv32f_pkg;

    localparam logic [2:0] FRM_RNE = 3'b000;
    localparam logic [2:0] FRM_RTZ = 3'b001;
    localparam logic [2:0] FRM_RDN = 3'b010;
    localparam logic [2:0] FRM_RUP = 3'b011;
    localparam logic [2:0] FRM_RMM = 3'b100;

    localparam int FP_BIAS = 127;

    typedef enum logic [1:0] {
        CVT_IDLE,
        CVT_NORM,
        CVT_RND,
        CVT_OUT
    } cvt_state_e;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter.
// An all-zero input reports 32.
module lzc32 (
    input  logic [31:0] a,
    output logic [5:0]  cnt
);

    // Scan upward so the most significant set bit wins.
    always_comb begin
        cnt = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) begin
                cnt = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/i2f_seq.sv
// Sequential int32/uint32 to binary32 converter (FCVT.S.W / FCVT.S.WU).
// Capture, normalize, round and emit over four cycles.
module i2f_seq
    import riscv32f_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic        is_unsigned,
    input  logic [2:0]  frm,
    output logic        busy,
    output logic        done,
    output logic [31:0] d,
    output logic        NX,
    output logic        invalid
);

    // Exponent of a value whose top set bit is bit 31.
    localparam logic [7:0] EXP_TOP = 8'(FP_BIAS + 31);

    cvt_state_e  state;
    cvt_state_e  state_nx;

    logic [31:0] norm;
    logic [7:0]  exp;
    logic        sign;
    logic        zero;
    logic [2:0]  frm_q;
    logic        guard;
    logic        sticky;
    logic [22:0] frac;

    logic [5:0]  lz;
    logic        inc;
    logic        carry;
    logic [22:0] frac_rnd;
    logic        rnd_guard;
    logic        rnd_sticky;
    logic        rnd_lsb;
    logic        frm_bad;

    lzc32 u_lzc (
        .a   (norm),
        .cnt (lz)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CVT_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state sequencing; a start is only honoured from IDLE.
    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        case (state)
            CVT_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = CVT_NORM;
                end
            end
            CVT_NORM: state_nx = CVT_RND;
            CVT_RND:  state_nx = CVT_OUT;
            CVT_OUT:  state_nx = CVT_IDLE;
            default:  state_nx = CVT_IDLE;
        endcase
    end

    // Rounding decision on the normalized magnitude.
    always_comb begin
        rnd_guard  = norm[7];
        rnd_sticky = |norm[6:0];
        rnd_lsb    = norm[8];
        inc        = 1'b0;
        case (frm_q)
            FRM_RNE: inc = rnd_guard & (rnd_sticky | rnd_lsb);
            FRM_RTZ: inc = 1'b0;
            FRM_RDN: inc = sign & (rnd_guard | rnd_sticky);
            FRM_RUP: inc = ~sign & (rnd_guard | rnd_sticky);
            FRM_RMM: inc = rnd_guard;
            default: inc = 1'b0;
        endcase
        // All-ones mantissa wraps the fraction to zero and bumps exp.
        carry    = (&norm[31:8]) & inc;
        frac_rnd = norm[30:8] + {22'd0, inc};
        frm_bad  = frm_q > FRM_RMM;
    end

    // Datapath: capture, normalize, round, then publish the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            norm    <= '0;
            exp     <= '0;
            sign    <= 1'b0;
            zero    <= 1'b0;
            frm_q   <= FRM_RNE;
            guard   <= 1'b0;
            sticky  <= 1'b0;
            frac    <= '0;
            done    <= 1'b0;
            d       <= '0;
            NX      <= 1'b0;
            invalid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                CVT_IDLE: begin
                    if (start) begin
                        sign  <= a[31] & ~is_unsigned;
                        norm  <= (a[31] & ~is_unsigned) ? -a : a;
                        frm_q <= frm;
                    end
                end
                CVT_NORM: begin
                    norm <= norm << lz;
                    exp  <= EXP_TOP - {2'b00, lz};
                    zero <= lz[5];
                end
                CVT_RND: begin
                    frac   <= frac_rnd;
                    exp    <= exp + {7'd0, carry};
                    guard  <= rnd_guard;
                    sticky <= rnd_sticky;
                end
                CVT_OUT: begin
                    done <= 1'b1;
                    if (frm_bad) begin
                        d       <= '0;
                        NX      <= 1'b0;
                        invalid <= 1'b1;
                    end else if (zero) begin
                        d       <= '0;
                        NX      <= 1'b0;
                        invalid <= 1'b0;
                    end else begin
                        d       <= {sign, exp, frac};
                        NX      <= guard | sticky;
                        invalid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2f_seq.sv
// Self-checking bench for i2f_seq: directed corner cases, protocol
// checks and randomized operands against an arithmetic reference.
module tb_i2f_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic        is_unsigned;
    logic [2:0]  frm;
    logic        busy;
    logic        done;
    logic [31:0] d;
    logic        NX;
    logic        invalid;

    int errors;
    int checks;

    i2f_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .is_unsigned (is_unsigned),
        .frm         (frm),
        .busy        (busy),
        .done        (done),
        .d           (d),
        .NX          (NX),
        .invalid     (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact integer value, rounded by comparing the dropped
    // remainder with half an ulp.
    function automatic void model(input logic [31:0] av, input bit uns,
                                  input logic [2:0] rm,
                                  output logic [31:0] rd,
                                  output bit rnx, output bit rinv);
        bit     s;
        longint m, q, rem, half, bits;
        int     e, sh;
        bit     up;
        s    = av[31] && !uns;
        m    = s ? (longint'(1) << 32) - longint'({32'd0, av})
                 : longint'({32'd0, av});
        rd   = '0;
        rnx  = 0;
        rinv = 0;
        if (rm > 3'd4) begin
            rinv = 1;
        end else if (m != 0) begin
            e = 0;
            for (int i = 0; i < 40; i++) begin
                if (m >= (longint'(1) << i)) e = i;
            end
            if (e <= 23) begin
                q   = m << (23 - e);
                rem = 0;
                half = 1;
            end else begin
                sh   = e - 23;
                q    = m >> sh;
                rem  = m - (q << sh);
                half = longint'(1) << (sh - 1);
            end
            case (rm)
                3'd0: up = (rem > half) || (rem == half && rem != 0 && q[0]);
                3'd1: up = 0;
                3'd2: up = s && rem != 0;
                3'd3: up = !s && rem != 0;
                default: up = rem != 0 && rem >= half;
            endcase
            if (up) q = q + 1;
            bits = (longint'(s) << 31) + (longint'(e + 127) << 23)
                   + q - (longint'(1) << 23);
            rd  = bits[31:0];
            rnx = rem != 0;
        end
    endfunction

    // Present one request for a single cycle, then scramble the inputs.
    task automatic issue(input logic [31:0] av, input bit uns,
                         input logic [2:0] rm);
        a           = av;
        is_unsigned = uns;
        frm         = rm;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        a           = $urandom;
        is_unsigned = 1'($urandom);
        frm         = 3'($urandom);
    endtask

    // Count edges from the start edge until done; optionally poke start
    // while busy. Returns at the negedge where done is seen.
    task automatic wait_done(input bit poke, output int lat);
        lat = 1;
        while (!done && lat < 8) begin
            chk("busy_during", {31'd0, busy}, 32'd1);
            if (poke) begin
                start = (lat == 1);
                a     = $urandom;
                frm   = 3'($urandom_range(0, 4));
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic convert(input logic [31:0] av, input bit uns,
                           input logic [2:0] rm, input bit poke,
                           output logic [31:0] gd, output bit gnx);
        logic [31:0] ed;
        bit          enx, einv;
        int          lat;
        model(av, uns, rm, ed, enx, einv);
        issue(av, uns, rm);
        wait_done(poke, lat);
        chk("latency", lat, 32'd4);
        chk("d", d, ed);
        chk("nx", {31'd0, NX}, {31'd0, enx});
        chk("invalid", {31'd0, invalid}, {31'd0, einv});
        gd  = d;
        gnx = NX;
        @(negedge clk);
        chk("done_width", {31'd0, done}, 32'd0);
        chk("idle_after", {31'd0, busy}, 32'd0);
        chk("d_hold", d, ed);
    endtask

    logic [31:0] gd;
    bit          gnx;
    int          lat;
    int          dones;
    logic [31:0] ra;
    logic [2:0]  rm;
    bit          ru;

    initial begin
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        a           = '0;
        is_unsigned = 1'b0;
        frm         = 3'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_d", d, 32'd0);
        chk("rst_nx", {31'd0, NX}, 32'd0);
        chk("rst_inv", {31'd0, invalid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        convert(32'd2, 0, 3'd0, 0, gd, gnx);
        chk("two", gd, 32'h4000_0000);
        chk("two_nx", {31'd0, gnx}, 32'd0);
        convert(32'hFFFF_FFFF, 0, 3'd0, 0, gd, gnx);
        chk("m1", gd, 32'hBF80_0000);
        convert(32'd0, 0, 3'd3, 0, gd, gnx);
        chk("zero", gd, 32'h0);
        chk("zero_nx", {31'd0, gnx}, 32'd0);
        convert(32'h0100_0001, 0, 3'd0, 0, gd, gnx);
        chk("tie_rne", gd, 32'h4B80_0000);
        chk("tie_nx", {31'd0, gnx}, 32'd1);
        convert(32'h0100_0001, 0, 3'd4, 0, gd, gnx);
        chk("tie_rmm", gd, 32'h4B80_0001);
        convert(32'h0100_0001, 0, 3'd3, 0, gd, gnx);
        chk("tie_rup", gd, 32'h4B80_0001);
        convert(32'h0100_0001, 0, 3'd1, 0, gd, gnx);
        chk("tie_rtz", gd, 32'h4B80_0000);
        convert(32'h0100_0003, 0, 3'd0, 0, gd, gnx);
        chk("tie_odd", gd, 32'h4B80_0002);
        convert(32'hFEFF_FFFF, 0, 3'd2, 0, gd, gnx);
        chk("neg_rdn", gd, 32'hCB80_0001);
        convert(32'hFEFF_FFFF, 0, 3'd1, 0, gd, gnx);
        chk("neg_rtz", gd, 32'hCB80_0000);
        convert(32'h8000_0000, 0, 3'd0, 0, gd, gnx);
        chk("intmin", gd, 32'hCF00_0000);
        chk("intmin_nx", {31'd0, gnx}, 32'd0);
        convert(32'h7FFF_FFFF, 0, 3'd0, 0, gd, gnx);
        chk("max_rne", gd, 32'h4F00_0000);
        convert(32'h7FFF_FFFF, 0, 3'd1, 0, gd, gnx);
        chk("max_rtz", gd, 32'h4EFF_FFFF);
        chk("max_nx", {31'd0, gnx}, 32'd1);
        convert(32'hFFFF_FFFF, 1, 3'd0, 0, gd, gnx);
        chk("umax", gd, 32'h4F80_0000);
        convert(32'd12345, 0, 3'd5, 0, gd, gnx);
        chk("bad_frm_d", gd, 32'h0);
        chk("bad_frm_inv", {31'd0, invalid}, 32'd1);

        // Start while busy must not disturb the conversion in flight.
        convert(32'h0000_0300, 0, 3'd0, 1, gd, gnx);
        chk("poke", gd, 32'h4440_0000);

        // Back-to-back: second start in the done cycle.
        issue(32'd5, 0, 3'd0);
        wait_done(0, lat);
        chk("b2b_lat1", lat, 32'd4);
        chk("b2b_d1", d, 32'h40A0_0000);
        issue(32'hFFFF_FFFD, 0, 3'd0);
        wait_done(0, lat);
        chk("b2b_lat2", lat, 32'd4);
        chk("b2b_d2", d, 32'hC040_0000);
        @(negedge clk);

        // Reset mid-operation abandons the conversion.
        issue(32'd7, 0, 3'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_d", d, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("mid_rst_nodone", dones, 32'd0);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0: ra = $urandom_range(0, 300);
                1: ra = 32'hFFFF_FFFF - $urandom_range(0, 300);
                2: ra = $urandom << $urandom_range(0, 31);
                default: ra = $urandom;
            endcase
            ru = 1'($urandom);
            rm = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7))
                                              : 3'($urandom_range(0, 4));
            convert(ra, ru, rm, 1'($urandom_range(0, 3) == 0), gd, gnx);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
